// File: rtl/fsk_dds_loader_if.sv
// -----------------------------------------------------------------------------
// fsk_dds_loader_if
//   Byte handshake between the FSK DDS command loader and the SPI master,
//   plus the DDS chip select that the SPI master does not generate itself.
//
//   TX_Byte   loader -> SPI  byte to shift out, MSB first
//   TX_Valid  loader -> SPI  single-cycle strobe, TX_Byte valid
//   TX_Ready  SPI -> loader  SPI master can accept a byte (registered)
//   CS_n      loader -> DDS  chip select, active low
//
//   Modports: master = loader side, slave = SPI master / DDS side.
// -----------------------------------------------------------------------------
interface fsk_dds_loader_if;
   logic [7:0] TX_Byte;
   logic       TX_Valid;
   logic       TX_Ready;
   logic       CS_n;

   modport master (
      output TX_Byte,
      output TX_Valid,
      output CS_n,
      input  TX_Ready
   );

   modport slave (
      input  TX_Byte,
      input  TX_Valid,
      input  CS_n,
      output TX_Ready
   );
endinterface

// File: rtl/fsk_dds_loader.sv
// -----------------------------------------------------------------------------
// fsk_dds_loader
//   Command sequencer in front of the SPI master of the FSK transmitter.
//   On i_Init it programs an AD9833-style DDS with six 16-bit words
//   (RESET, FREQ0 lo/hi, FREQ1 lo/hi, exit reset). After that every accepted
//   FSK symbol becomes one control word selecting FREQ0 or FREQ1. Each word is
//   sent as two bytes, MSB first, framed by a chip select with programmable
//   setup, hold and inter-frame gap.
//
//   Parameters
//     CS_SETUP_CLKS  cycles from CS_n falling to the first byte offer (>=1)
//     CS_HOLD_CLKS   cycles CS_n stays low after the low byte completes (>=1)
//     CS_GAP_CLKS    minimum cycles CS_n stays high between frames (>=1)
//
//   Ports
//     i_Clk, i_Reset_n      clock, asynchronous active-low reset
//     i_Init                start init sequence (sampled in IDLE only)
//     i_Freq0_Word/1_Word   28-bit tuning words, captured with i_Init
//     i_Sym_Valid, i_Sym    symbol stream (0 -> FREQ0, 1 -> FREQ1)
//     o_Sym_Ready           symbol accepted when high together with valid
//     o_Busy                FSM outside IDLE
//     o_Init_Done           DDS initialised, cleared only by reset
//     spi_m                 byte handshake + chip select (master modport)
//
//   Build option
//     FSK_DDS_DEDUP_EN      when defined, a symbol equal to the previous one
//                           is accepted without sending a frame.
// -----------------------------------------------------------------------------
module fsk_dds_loader #(
   parameter int CS_SETUP_CLKS = 2,
   parameter int CS_HOLD_CLKS  = 2,
   parameter int CS_GAP_CLKS   = 4
) (
   input  logic             i_Clk,
   input  logic             i_Reset_n,
   input  logic             i_Init,
   input  logic [27:0]      i_Freq0_Word,
   input  logic [27:0]      i_Freq1_Word,
   input  logic             i_Sym_Valid,
   input  logic             i_Sym,
   output logic             o_Sym_Ready,
   output logic             o_Busy,
   output logic             o_Init_Done,
   fsk_dds_loader_if.master spi_m
);

   localparam int MAX_AB   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
   localparam int MAX_CLKS = (MAX_AB > CS_GAP_CLKS) ? MAX_AB : CS_GAP_CLKS;
   localparam int CNT_W    = $clog2(MAX_CLKS) + 1;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CLKS - 1);
   localparam logic [2:0]       INIT_LAST  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CS_SETUP,
      S_SEND_HI,
      S_WAIT_HI,
      S_SEND_LO,
      S_WAIT_LO,
      S_CS_HOLD,
      S_CS_GAP
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic             init_seq_q;
   logic             sym_q;
   logic             last_sym_q;
   logic [27:0]      f0_q;
   logic [27:0]      f1_q;
   logic [7:0]       tx_byte_q;
   logic             tx_valid_q;
   logic             cs_n_q;
   logic             busy_q;
   logic             sym_ready_q;
   logic             init_done_q;

   logic [15:0]      word_d;
   logic             last_word_d;
   logic             sym_accept_d;
   logic             sym_frame_d;

   // Word for the current frame: init table entry or FSELECT control word.
   always_comb begin
      word_d = 16'h2000;
      if (init_seq_q) begin
         case (idx_q)
            3'd0:    word_d = 16'h2100;
            3'd1:    word_d = {2'b01, f0_q[13:0]};
            3'd2:    word_d = {2'b01, f0_q[27:14]};
            3'd3:    word_d = {2'b10, f1_q[13:0]};
            3'd4:    word_d = {2'b10, f1_q[27:14]};
            default: word_d = 16'h2000;
         endcase
      end else begin
         word_d = sym_q ? 16'h2800 : 16'h2000;
      end
   end

   // A symbol frame is one word; an init sequence ends after index 5.
   always_comb begin
      last_word_d = !init_seq_q || (idx_q == INIT_LAST);
   end

   // i_Init wins over a symbol offered in the same IDLE cycle.
   always_comb begin
      sym_accept_d = (state_q == S_IDLE) && !i_Init && i_Sym_Valid && init_done_q;
`ifdef FSK_DDS_DEDUP_EN
      sym_frame_d  = sym_accept_d && (i_Sym != last_sym_q);
`else
      sym_frame_d  = sym_accept_d;
`endif
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         init_seq_q  <= 1'b0;
         sym_q       <= 1'b0;
         last_sym_q  <= 1'b0;
         f0_q        <= '0;
         f1_q        <= '0;
         tx_byte_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         sym_ready_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         // Strobe is one cycle wide by construction.
         tx_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (i_Init) begin
                  f0_q        <= i_Freq0_Word;
                  f1_q        <= i_Freq1_Word;
                  init_seq_q  <= 1'b1;
                  idx_q       <= 3'd0;
                  cnt_q       <= '0;
                  cs_n_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  sym_ready_q <= 1'b0;
                  state_q     <= S_CS_SETUP;
               end else if (sym_accept_d) begin
                  last_sym_q <= i_Sym;
                  if (sym_frame_d) begin
                     sym_q       <= i_Sym;
                     init_seq_q  <= 1'b0;
                     idx_q       <= 3'd0;
                     cnt_q       <= '0;
                     cs_n_q      <= 1'b0;
                     busy_q      <= 1'b1;
                     sym_ready_q <= 1'b0;
                     state_q     <= S_CS_SETUP;
                  end
               end
            end

            // The last setup cycle can already issue the high byte so the
            // strobe lands exactly CS_SETUP_CLKS cycles after CS_n falls.
            S_CS_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_q <= '0;
                  if (spi_m.TX_Ready) begin
                     tx_byte_q  <= word_d[15:8];
                     tx_valid_q <= 1'b1;
                     state_q    <= S_WAIT_HI;
                  end else begin
                     state_q    <= S_SEND_HI;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_SEND_HI: begin
               if (spi_m.TX_Ready) begin
                  tx_byte_q  <= word_d[15:8];
                  tx_valid_q <= 1'b1;
                  state_q    <= S_WAIT_HI;
               end
            end

            // While the strobe is high the master's registered ready is stale.
            S_WAIT_HI: begin
               if (!tx_valid_q && spi_m.TX_Ready) begin
                  state_q <= S_SEND_LO;
               end
            end

            S_SEND_LO: begin
               if (spi_m.TX_Ready) begin
                  tx_byte_q  <= word_d[7:0];
                  tx_valid_q <= 1'b1;
                  state_q    <= S_WAIT_LO;
               end
            end

            S_WAIT_LO: begin
               if (!tx_valid_q && spi_m.TX_Ready) begin
                  cnt_q   <= '0;
                  state_q <= S_CS_HOLD;
               end
            end

            S_CS_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  cs_n_q  <= 1'b1;
                  state_q <= S_CS_GAP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_CS_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (last_word_d) begin
                     // Init leaves the DDS on FREQ0, so the symbol history
                     // restarts at 0.
                     if (init_seq_q) begin
                        init_done_q <= 1'b1;
                        last_sym_q  <= 1'b0;
                     end
                     busy_q      <= 1'b0;
                     sym_ready_q <= init_seq_q | init_done_q;
                     state_q     <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     cs_n_q  <= 1'b0;
                     state_q <= S_CS_SETUP;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign spi_m.TX_Byte  = tx_byte_q;
   assign spi_m.TX_Valid = tx_valid_q;
   assign spi_m.CS_n     = cs_n_q;
   assign o_Busy         = busy_q;
   assign o_Sym_Ready    = sym_ready_q;
   assign o_Init_Done    = init_done_q;

endmodule

// File: tb/tb_fsk_dds_loader.sv
// -----------------------------------------------------------------------------
// tb_fsk_dds_loader
//   Directed bench for fsk_dds_loader: table of init/symbol transactions with
//   expected byte streams, plus hand-written sequences for reset values,
//   symbols before init, a stalled SPI master, exact CS timing and a reset
//   asserted in the middle of a frame. A small SPI master model drops ready
//   for a few cycles after each accepted byte.
// -----------------------------------------------------------------------------
module tb_fsk_dds_loader;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;
   localparam int GAP   = 4;
   localparam int NS    = 60;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init;
   logic [27:0] f0;
   logic [27:0] f1;
   logic        sym_valid;
   logic        sym;
   logic        sym_ready;
   logic        busy;
   logic        init_done;
   logic        stall;

   always #5 clk = ~clk;

   fsk_dds_loader_if spi();

   fsk_dds_loader #(
      .CS_SETUP_CLKS(SETUP),
      .CS_HOLD_CLKS (HOLD),
      .CS_GAP_CLKS  (GAP)
   ) dut (
      .i_Clk       (clk),
      .i_Reset_n   (rst_n),
      .i_Init      (init),
      .i_Freq0_Word(f0),
      .i_Freq1_Word(f1),
      .i_Sym_Valid (sym_valid),
      .i_Sym       (sym),
      .o_Sym_Ready (sym_ready),
      .o_Busy      (busy),
      .o_Init_Done (init_done),
      .spi_m       (spi)
   );

   // SPI master model: registered ready, busy 4 cycles after each byte.
   logic       mdl_rdy;
   logic [2:0] mdl_cnt;
   assign spi.TX_Ready = mdl_rdy & ~stall;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_rdy <= 1'b1;
         mdl_cnt <= 3'd0;
      end else if (spi.TX_Valid && spi.TX_Ready) begin
         mdl_rdy <= 1'b0;
         mdl_cnt <= 3'd3;
      end else if (!mdl_rdy) begin
         if (mdl_cnt == 3'd0) mdl_rdy <= 1'b1;
         else                 mdl_cnt <= mdl_cnt - 3'd1;
      end
   end

   // Bus monitor on the falling edge.
   logic [7:0] cap_q[$];
   int         n_frames   = 0;
   int         viol       = 0;
   logic       prev_valid = 1'b0;
   logic       prev_cs    = 1'b1;

   always @(negedge clk) begin
      if (spi.TX_Valid) cap_q.push_back(spi.TX_Byte);
      if (spi.TX_Valid && spi.CS_n) viol++;
      if (spi.TX_Valid && prev_valid) viol++;
      if (prev_cs && !spi.CS_n) n_frames++;
      prev_valid = spi.TX_Valid;
      prev_cs    = spi.CS_n;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 3000) begin
         tick();
         k++;
      end
      chk({nm, "_idle"}, 32'(busy), 0);
   endtask

   task automatic chk_bytes(input string nm, input int base, input int nb,
                            input logic [95:0] exp_b);
      chk({nm, "_count"}, 32'(cap_q.size() - base), 32'(nb));
      for (int j = 0; j < nb; j++) begin
         if (base + j < cap_q.size())
            chk($sformatf("%s_byte%0d", nm, j), 32'(cap_q[base + j]), 32'(exp_b[95 - 8*j -: 8]));
      end
   endtask

   typedef struct {
      bit          is_init;
      logic [27:0] f0;
      logic [27:0] f1;
      bit          sym;
      int          nb;
      logic [95:0] exp_b;
   } vec_t;

   vec_t tv [7];

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int fb;
      int nv;
      int vhi;
      int vlo;
      int rr;
      int bad_busy;
      logic cs_a [NS];
      logic v_a  [NS];
      logic r_a  [NS];
      logic sr_a [NS];
      logic b_a  [NS];

      // Transaction table: first byte of a frame in the top bits of exp_b.
      tv[0] = '{1'b1, 28'hFFFFFFF, 28'h0000001, 1'b0, 12, 96'h2100_7FFF_7FFF_8001_8000_2000};
      tv[1] = '{1'b0, 28'h0, 28'h0, 1'b1, 2, 96'h2800_0000_0000_0000_0000_0000};
`ifdef FSK_DDS_DEDUP_EN
      tv[2] = '{1'b0, 28'h0, 28'h0, 1'b1, 0, 96'h0};
`else
      tv[2] = '{1'b0, 28'h0, 28'h0, 1'b1, 2, 96'h2800_0000_0000_0000_0000_0000};
`endif
      tv[3] = '{1'b0, 28'h0, 28'h0, 1'b0, 2, 96'h2000_0000_0000_0000_0000_0000};
`ifdef FSK_DDS_DEDUP_EN
      tv[4] = '{1'b0, 28'h0, 28'h0, 1'b0, 0, 96'h0};
`else
      tv[4] = '{1'b0, 28'h0, 28'h0, 1'b0, 2, 96'h2000_0000_0000_0000_0000_0000};
`endif
      tv[5] = '{1'b1, 28'h0000ABC, 28'h1234567, 1'b0, 12, 96'h2100_4ABC_4000_8567_848D_2000};
`ifdef FSK_DDS_DEDUP_EN
      tv[6] = '{1'b0, 28'h0, 28'h0, 1'b0, 0, 96'h0};
`else
      tv[6] = '{1'b0, 28'h0, 28'h0, 1'b0, 2, 96'h2000_0000_0000_0000_0000_0000};
`endif

      rst_n = 1'b1; init = 1'b0; f0 = '0; f1 = '0;
      sym_valid = 1'b0; sym = 1'b0; stall = 1'b0;

      // Reset values, asserted between clock edges.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx_byte",   32'(spi.TX_Byte),  0);
      chk("rst_tx_valid",  32'(spi.TX_Valid), 0);
      chk("rst_cs_n",      32'(spi.CS_n),     1);
      chk("rst_busy",      32'(busy),         0);
      chk("rst_init_done", 32'(init_done),    0);
      chk("rst_sym_ready", 32'(sym_ready),    0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Symbols before init are refused.
      base = cap_q.size();
      sym = 1'b1; sym_valid = 1'b1;
      repeat (10) tick();
      chk("preinit_sym_ready", 32'(sym_ready), 0);
      chk("preinit_busy",      32'(busy),      0);
      chk("preinit_bytes",     32'(cap_q.size() - base), 0);
      sym_valid = 1'b0;

      // Init with the SPI master stalled; a second i_Init while busy is ignored.
      stall = 1'b1;
      f0 = 28'h0000ABC; f1 = 28'h1234567;
      base = cap_q.size(); fb = n_frames;
      init = 1'b1; tick(); init = 1'b0;
      repeat (20) tick();
      chk("stall_cs_n",  32'(spi.CS_n), 0);
      chk("stall_busy",  32'(busy), 1);
      chk("stall_bytes", 32'(cap_q.size() - base), 0);
      f0 = 28'hFFFFFFF; f1 = 28'h0000000;
      init = 1'b1; tick(); init = 1'b0;
      stall = 1'b0;
      wait_idle("stall_init");
      chk_bytes("stall_init", base, 12, 96'h2100_4ABC_4000_8567_848D_2000);
      chk("stall_init_frames", 32'(n_frames - fb), 6);
      chk("stall_init_done",   32'(init_done), 1);

      // Table-driven transactions.
      for (int i = 0; i < 7; i++) begin
         base = cap_q.size(); fb = n_frames;
         if (tv[i].is_init) begin
            f0 = tv[i].f0; f1 = tv[i].f1; init = 1'b1;
         end else begin
            sym = tv[i].sym; sym_valid = 1'b1;
         end
         tick();
         init = 1'b0; sym_valid = 1'b0;
         repeat (3) tick();
         wait_idle($sformatf("vec%0d", i));
         chk_bytes($sformatf("vec%0d", i), base, tv[i].nb, tv[i].exp_b);
         chk($sformatf("vec%0d_frames", i), 32'(n_frames - fb), 32'(tv[i].nb / 2));
         chk($sformatf("vec%0d_done", i),   32'(init_done), 1);
         chk($sformatf("vec%0d_ready", i),  32'(sym_ready), 1);
      end

      // Exact CS timing of one symbol frame (previous symbol was 0).
      base = cap_q.size();
      sym = 1'b1; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      for (int k = 0; k < NS; k++) begin
         cs_a[k] = spi.CS_n; v_a[k] = spi.TX_Valid; r_a[k] = spi.TX_Ready;
         sr_a[k] = sym_ready; b_a[k] = busy;
         tick();
      end
      vhi = -1; vlo = -1; rr = -1;
      for (int k = 0; k < NS; k++) begin
         if (v_a[k] && vhi < 0) vhi = k;
         else if (v_a[k] && vhi >= 0 && vlo < 0) vlo = k;
      end
      if (vlo >= 0) begin
         for (int k = vlo + 1; k < NS; k++) if (r_a[k] && rr < 0) rr = k;
      end
      chk("tim_cs_fall",  32'(cs_a[0]), 0);
      chk("tim_first_tx", 32'(vhi), 32'(SETUP));
      if (rr >= 0 && rr + HOLD + GAP + 1 < NS) begin
         chk("tim_hold_low",   32'(cs_a[rr + HOLD]), 0);
         chk("tim_cs_rise",    32'(cs_a[rr + HOLD + 1]), 1);
         chk("tim_gap_high",   32'(cs_a[rr + HOLD + GAP]), 1);
         chk("tim_rdy_in_gap", 32'(sr_a[rr + HOLD + GAP]), 0);
         chk("tim_rdy_rise",   32'(sr_a[rr + HOLD + GAP + 1]), 1);
         chk("tim_busy_end",   32'(b_a[rr + HOLD + GAP + 1]), 0);
         bad_busy = 0;
         for (int k = 0; k <= rr + HOLD + GAP; k++) if (!b_a[k] || sr_a[k]) bad_busy++;
         chk("tim_busy_frame", 32'(bad_busy), 0);
      end else begin
         chk("tim_ready_return", 32'(rr), 32'(vlo + 1));
      end
      chk_bytes("tim", base, 2, 96'h2800_0000_0000_0000_0000_0000);

      // Reset while the low byte strobe is on the bus.
      sym = 1'b0; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      nv = 0;
      for (int k = 0; k < 200 && nv < 2; k++) begin
         if (spi.TX_Valid) nv++;
         if (nv < 2) tick();
      end
      chk("midrst_second_byte", 32'(nv), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cs_n",      32'(spi.CS_n),     1);
      chk("midrst_tx_valid",  32'(spi.TX_Valid), 0);
      chk("midrst_init_done", 32'(init_done),    0);
      chk("midrst_busy",      32'(busy),         0);
      tick();
      rst_n = 1'b1;
      tick();
      base = cap_q.size();
      sym = 1'b1; sym_valid = 1'b1;
      repeat (10) tick();
      sym_valid = 1'b0;
      chk("postrst_sym_ready", 32'(sym_ready), 0);
      chk("postrst_busy",      32'(busy), 0);
      chk("postrst_bytes",     32'(cap_q.size() - base), 0);

      chk("bus_protocol_violations", 32'(viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
